// File: rtl/iic_target_pkg.sv
// Shared I2C definitions: FSM state encodings, address/RW field positions,
// and bit-order helpers used by both the target and the initiator.
package iic_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } iic_state_t;

  // Address/RW field positions inside the assembled address byte
  localparam int unsigned C_LSB_ADDR_LO = 0;  // LSB-first: addr = b[6:0]
  localparam int unsigned C_LSB_RW_POS  = 7;  //            rw   = b[7]
  localparam int unsigned C_MSB_ADDR_LO = 1;  // MSB-first: addr = b[7:1]
  localparam int unsigned C_MSB_RW_POS  = 0;  //            rw   = b[0]

  // Append one wire bit to the partially assembled byte
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b,
                                          input logic lsb_first);
    return lsb_first ? {b, cur[7:1]} : {cur[6:0], b};
  endfunction

  function automatic logic [6:0] addr_field(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[C_LSB_ADDR_LO +: 7] : b[C_MSB_ADDR_LO +: 7];
  endfunction

  function automatic logic rw_field(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[C_LSB_RW_POS] : b[C_MSB_RW_POS];
  endfunction

  // Bit that goes on the wire in position idx (0 = first transmitted)
  function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] idx,
                                  input logic lsb_first);
    return lsb_first ? b[idx] : b[3'd7 - idx];
  endfunction

endpackage

// File: rtl/iic_line_sync.sv
// SCL/SDA synchronizers plus START/STOP/SCL-edge pulse generation.
// Stage 0/1 resynchronise, stage 2 is the previous sample for edge detection.
module iic_line_sync (
  input  logic w_clk_10MHz,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // Shift the raw pins into the three-stage chains
  always_comb begin
    scl_d = {scl_q[1:0], i_scl};
    sda_d = {sda_q[1:0], i_sda};
  end

  // Chains reset to the idle-bus level so no event fires out of reset
  always_ff @(posedge w_clk_10MHz or posedge i_rst) begin
    if (i_rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  // Bus conditions from the synchronized level and its previous sample
  always_comb begin
    o_sda   = sda_q[1];
    o_rise  = scl_q[1] & ~scl_q[2];
    o_fall  = ~scl_q[1] & scl_q[2];
    o_start = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    o_stop  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  end

endmodule

// File: rtl/iic_target.sv
// I2C target: fixed 7-bit address, ACKs every written byte, transmits
// caller-supplied bytes on reads. Never drives SCL, no clock stretching.
module iic_target
  import iic_target_pkg::*;
#(
  parameter logic [6:0] P_ADDRESS   = 7'h3C,
  parameter bit         P_LSB_FIRST = 1'b1
) (
  input  logic       w_clk_10MHz,
  input  logic       i_rst,
  inout  wire        io_SCL,
  inout  wire        io_SDA,
  input  logic [7:0] i_T_byte,
  output logic       o_T_byte_req,
  output logic [7:0] o_R_byte,
  output logic       o_R_valid,
  output logic       o_RW,
  output logic       o_busy,
  output logic       o_nack
);

  logic sda_s, ev_start, ev_stop, ev_rise, ev_fall;

  iic_line_sync u_line_sync (
    .w_clk_10MHz (w_clk_10MHz),
    .i_rst       (i_rst),
    .i_scl       (io_SCL),
    .i_sda       (io_SDA),
    .o_sda       (sda_s),
    .o_start     (ev_start),
    .o_stop      (ev_stop),
    .o_rise      (ev_rise),
    .o_fall      (ev_fall)
  );

  iic_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] r_byte_q, r_byte_d;
  logic       sda_low_q, sda_low_d;
  logic       ack_ph_q, ack_ph_d;   // second half of an ACK slot
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       r_valid_q, r_valid_d;
  logic       t_req_q, t_req_d;
  logic       nack_q, nack_d;
  logic [7:0] shifted;
  logic       sda_oe;

  // State register; async reset releases SDA immediately
  always_ff @(posedge w_clk_10MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      tx_q      <= 8'd0;
      r_byte_q  <= 8'd0;
      sda_low_q <= 1'b0;
      ack_ph_q  <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      r_valid_q <= 1'b0;
      t_req_q   <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      r_byte_q  <= r_byte_d;
      sda_low_q <= sda_low_d;
      ack_ph_q  <= ack_ph_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      r_valid_q <= r_valid_d;
      t_req_q   <= t_req_d;
      nack_q    <= nack_d;
    end
  end

  // Next-state logic; START/STOP outrank SCL edges in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    r_byte_d  = r_byte_q;
    sda_low_d = sda_low_q;
    ack_ph_d  = ack_ph_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    r_valid_d = 1'b0;
    t_req_d   = 1'b0;
    nack_d    = 1'b0;
    shifted   = shift_in(shift_q, sda_s, P_LSB_FIRST);
    if (ev_stop) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      ack_ph_d  = 1'b0;
    end else if (ev_start) begin
      state_d   = ST_ADDR;
      cnt_d     = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (ev_rise) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (addr_field(shifted, P_LSB_FIRST) == P_ADDRESS) begin
              rw_d     = rw_field(shifted, P_LSB_FIRST);
              busy_d   = 1'b1;
              ack_ph_d = 1'b0;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_RX_ACK: if (ev_fall) begin
          if (!ack_ph_q) begin
            sda_low_d = 1'b1;
            ack_ph_d  = 1'b1;
          end else begin
            ack_ph_d = 1'b0;
            cnt_d    = 4'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              // Load first read byte and present its first bit on this fall
              tx_d      = i_T_byte;
              t_req_d   = 1'b1;
              sda_low_d = ~tx_bit(i_T_byte, 3'd0, P_LSB_FIRST);
              cnt_d     = 4'd1;
              state_d   = ST_TX;
            end else begin
              sda_low_d = 1'b0;
              state_d   = ST_RX;
            end
          end
        end
        ST_RX: if (ev_rise) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            r_byte_d  = shifted;
            r_valid_d = 1'b1;
            ack_ph_d  = 1'b0;
            state_d   = ST_RX_ACK;
          end
        end
        ST_TX: if (ev_fall) begin
          if (cnt_q == 4'd8) begin
            sda_low_d = 1'b0;
            ack_ph_d  = 1'b0;
            state_d   = ST_TX_ACK;
          end else begin
            sda_low_d = ~tx_bit(tx_q, cnt_q[2:0], P_LSB_FIRST);
            cnt_d     = cnt_q + 4'd1;
          end
        end
        ST_TX_ACK: begin
          if (ev_rise) begin
            if (!sda_s) begin
              ack_ph_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (ev_fall && ack_ph_q) begin
            ack_ph_d  = 1'b0;
            tx_d      = i_T_byte;
            t_req_d   = 1'b1;
            sda_low_d = ~tx_bit(i_T_byte, 3'd0, P_LSB_FIRST);
            cnt_d     = 4'd1;
            state_d   = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs straight from registers; SDA is open-drain, SCL never driven
  always_comb begin
    sda_oe       = sda_low_q;
    o_R_byte     = r_byte_q;
    o_R_valid    = r_valid_q;
    o_T_byte_req = t_req_q;
    o_RW         = rw_q;
    o_busy       = busy_q;
    o_nack       = nack_q;
  end

  assign io_SDA = sda_oe ? 1'b0 : 1'bz;
  assign io_SCL = 1'bz;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: an LSB-first instance on bus 0 and an
// MSB-first instance on bus 1, driven by a bit-level initiator model.
`timescale 1ns/1ps
module tb_iic_target;
  import iic_target_pkg::*;

  localparam int Q = 5;  // quarter SCL period in clocks

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic       rst;
  logic       scl_rel, sda_rel, bus_sel;
  logic [7:0] t_byte;
  int         tests_run = 0;
  int         tests_failed = 0;

  wire scl0, sda0, scl1, sda1;
  pullup (scl0);
  pullup (sda0);
  pullup (scl1);
  pullup (sda1);
  assign scl0 = (!bus_sel && !scl_rel) ? 1'b0 : 1'bz;
  assign sda0 = (!bus_sel && !sda_rel) ? 1'b0 : 1'bz;
  assign scl1 = (bus_sel && !scl_rel) ? 1'b0 : 1'bz;
  assign sda1 = (bus_sel && !sda_rel) ? 1'b0 : 1'bz;
  wire sda_obs = bus_sel ? sda1 : sda0;

  logic       t_req0, r_valid0, rw0, busy0, nack0;
  logic [7:0] r_byte0;
  logic       t_req1, r_valid1, rw1, busy1, nack1;
  logic [7:0] r_byte1;

  iic_target #(.P_ADDRESS(7'h3C), .P_LSB_FIRST(1'b1)) u_dut (
    .w_clk_10MHz (clk), .i_rst (rst), .io_SCL (scl0), .io_SDA (sda0),
    .i_T_byte (t_byte), .o_T_byte_req (t_req0), .o_R_byte (r_byte0),
    .o_R_valid (r_valid0), .o_RW (rw0), .o_busy (busy0), .o_nack (nack0)
  );

  iic_target #(.P_ADDRESS(7'h3C), .P_LSB_FIRST(1'b0)) u_dut_msb (
    .w_clk_10MHz (clk), .i_rst (rst), .io_SCL (scl1), .io_SDA (sda1),
    .i_T_byte (t_byte), .o_T_byte_req (t_req1), .o_R_byte (r_byte1),
    .o_R_valid (r_valid1), .o_RW (rw1), .o_busy (busy1), .o_nack (nack1)
  );

  // Event monitor (sampled on the falling clock edge)
  logic [7:0] rx0_q[$];
  logic [7:0] rx1_q[$];
  int treq0_cnt = 0, nack0_cnt = 0, drive0_cnt = 0, busy0_cnt = 0, idle0_cnt = 0;
  int treq1_cnt = 0, nack1_cnt = 0, busy1_cnt = 0;
  always @(negedge clk) begin
    if (r_valid0) rx0_q.push_back(r_byte0);
    if (r_valid1) rx1_q.push_back(r_byte1);
    if (t_req0) treq0_cnt++;
    if (t_req1) treq1_cnt++;
    if (nack0) nack0_cnt++;
    if (nack1) nack1_cnt++;
    if (busy0) busy0_cnt++;
    if (busy1 || rw1) busy1_cnt++;
    if (!bus_sel && sda_rel && sda0 === 1'b0) drive0_cnt++;
    if (u_dut.state_q == ST_IDLE) idle0_cnt++;
  end

  // ---------------- initiator model ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START from idle, or repeated START from SCL low
  task automatic bus_start;
    sda_rel = 1'b1; wait_clk(Q);
    scl_rel = 1'b1; wait_clk(Q);
    sda_rel = 1'b0; wait_clk(Q);
    scl_rel = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop;
    sda_rel = 1'b0; wait_clk(Q);
    scl_rel = 1'b1; wait_clk(Q);
    sda_rel = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_rel = b;    wait_clk(Q);
    scl_rel = 1'b1; wait_clk(2 * Q);
    scl_rel = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_rel = 1'b1; wait_clk(Q);
    scl_rel = 1'b1; wait_clk(Q);
    b = sda_obs;    wait_clk(Q);
    scl_rel = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic lsb);
    for (int i = 0; i < 8; i++) send_bit(lsb ? v[i] : v[7 - i]);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic lsb);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      if (lsb) v[i] = b; else v[7 - i] = b;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    tests_run++;
    if (sda0 !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b want 1", sda0); end
    tests_run++;
    if ({r_byte0, r_valid0, t_req0, nack0, rw0, busy0} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got byte=%h v=%b req=%b nack=%b rw=%b busy=%b want all 0",
               r_byte0, r_valid0, t_req0, nack0, rw0, busy0);
    end
    rst = 1'b0;
    wait_clk(2);
    $display("[TB] reset done");
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    int base = rx0_q.size();
    bus_start();
    send_byte(8'h3C, 1'b1); recv_bit(a0);
    send_byte(8'hA5, 1'b1); recv_bit(a1);
    send_byte(8'h5A, 1'b1); recv_bit(a2);
    tests_run++;
    if ({a0, a1, a2} !== 3'b000) begin tests_failed++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
    tests_run++;
    if (rw0 !== 1'b0) begin tests_failed++; $display("FAIL write_rw: got %b want 0", rw0); end
    tests_run++;
    if (rx0_q.size() - base != 2) begin
      tests_failed++; $display("FAIL write_count: got %0d want 2", rx0_q.size() - base);
    end else begin
      tests_run++;
      if (rx0_q[base] !== 8'hA5) begin tests_failed++; $display("FAIL write_byte0: got %h want a5", rx0_q[base]); end
      tests_run++;
      if (rx0_q[base + 1] !== 8'h5A) begin tests_failed++; $display("FAIL write_byte1: got %h want 5a", rx0_q[base + 1]); end
    end
    // STOP with busy timing
    sda_rel = 1'b0; wait_clk(Q);
    scl_rel = 1'b1; wait_clk(Q);
    tests_run++;
    if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL write_busy_before_stop: got %b want 1", busy0); end
    sda_rel = 1'b1;
    wait_clk(2);
    tests_run++;
    if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL write_busy_stop_plus2: got %b want 1", busy0); end
    wait_clk(2);
    tests_run++;
    if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL write_busy_stop_plus4: got %b want 0", busy0); end
    wait_clk(Q);
    $display("[TB] write a5 5a done");
  endtask

  task automatic test_mismatch;
    logic a0, a1;
    int rx_base = rx0_q.size();
    int drv_base = drive0_cnt;
    int busy_base = busy0_cnt;
    bus_start();
    send_byte(8'h3D, 1'b1); recv_bit(a0);
    send_byte(8'hFF, 1'b1); recv_bit(a1);
    bus_stop();
    tests_run++;
    if ({a0, a1} !== 2'b11) begin tests_failed++; $display("FAIL mismatch_ack: got %b want 11", {a0, a1}); end
    tests_run++;
    if (drive0_cnt != drv_base) begin tests_failed++; $display("FAIL mismatch_drive: got %0d low cycles want 0", drive0_cnt - drv_base); end
    tests_run++;
    if (busy0_cnt != busy_base) begin tests_failed++; $display("FAIL mismatch_busy: got %0d busy cycles want 0", busy0_cnt - busy_base); end
    tests_run++;
    if (rx0_q.size() != rx_base) begin tests_failed++; $display("FAIL mismatch_rvalid: got %0d want 0", rx0_q.size() - rx_base); end
    $display("[TB] mismatch addr 3d done");
  endtask

  task automatic test_read;
    logic       a0;
    logic [7:0] d0, d1;
    int treq_base = treq0_cnt;
    int nack_base = nack0_cnt;
    t_byte = 8'h81;
    bus_start();
    send_byte(8'hBC, 1'b1); recv_bit(a0);
    t_byte = 8'h7E;
    recv_byte(d0, 1'b1); send_bit(1'b0);
    recv_byte(d1, 1'b1); send_bit(1'b1);
    wait_clk(2);
    tests_run++;
    if (a0 !== 1'b0) begin tests_failed++; $display("FAIL read_addr_ack: got %b want 0", a0); end
    tests_run++;
    if (rw0 !== 1'b1) begin tests_failed++; $display("FAIL read_rw: got %b want 1", rw0); end
    tests_run++;
    if (d0 !== 8'h81) begin tests_failed++; $display("FAIL read_byte0: got %h want 81", d0); end
    tests_run++;
    if (d1 !== 8'h7E) begin tests_failed++; $display("FAIL read_byte1: got %h want 7e", d1); end
    tests_run++;
    if (treq0_cnt - treq_base != 2) begin tests_failed++; $display("FAIL read_treq: got %0d want 2", treq0_cnt - treq_base); end
    tests_run++;
    if (nack0_cnt - nack_base != 1) begin tests_failed++; $display("FAIL read_nack: got %0d want 1", nack0_cnt - nack_base); end
    tests_run++;
    if (sda0 !== 1'b1 || busy0 !== 1'b0) begin
      tests_failed++; $display("FAIL read_after_nack: got sda=%b busy=%b want 1/0", sda0, busy0);
    end
    bus_stop();
    $display("[TB] read 81 7e done");
  endtask

  task automatic test_rep_start;
    logic       a0, a1, a2;
    logic [7:0] d0;
    int rx_base = rx0_q.size();
    int idle_base;
    bus_start();
    send_byte(8'h3C, 1'b1); recv_bit(a0);
    send_byte(8'h11, 1'b1); recv_bit(a1);
    tests_run++;
    if (rw0 !== 1'b0) begin tests_failed++; $display("FAIL rs_rw_write: got %b want 0", rw0); end
    idle_base = idle0_cnt;
    t_byte = 8'h55;
    bus_start();
    send_byte(8'hBC, 1'b1); recv_bit(a2);
    recv_byte(d0, 1'b1); send_bit(1'b1);
    tests_run++;
    if ({a0, a1, a2} !== 3'b000) begin tests_failed++; $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); end
    tests_run++;
    if (rw0 !== 1'b1) begin tests_failed++; $display("FAIL rs_rw_read: got %b want 1", rw0); end
    tests_run++;
    if (rx0_q.size() - rx_base != 1 || rx0_q[rx0_q.size() - 1] !== 8'h11) begin
      tests_failed++; $display("FAIL rs_write_byte: got n=%0d last=%h want 1/11",
                               rx0_q.size() - rx_base, rx0_q[rx0_q.size() - 1]);
    end
    tests_run++;
    if (d0 !== 8'h55) begin tests_failed++; $display("FAIL rs_read_byte: got %h want 55", d0); end
    tests_run++;
    if (idle0_cnt != idle_base) begin tests_failed++; $display("FAIL rs_no_idle: got %0d idle cycles want 0", idle0_cnt - idle_base); end
    bus_stop();
    $display("[TB] repeated start 11 / 55 done");
  endtask

  task automatic test_abort;
    logic a0, a1;
    int rx_base = rx0_q.size();
    bus_start();
    send_byte(8'h3C, 1'b1); recv_bit(a0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    bus_stop();
    tests_run++;
    if (rx0_q.size() != rx_base) begin tests_failed++; $display("FAIL abort_rvalid: got %0d want 0", rx0_q.size() - rx_base); end
    bus_start();
    send_byte(8'h3C, 1'b1); recv_bit(a0);
    send_byte(8'hC3, 1'b1); recv_bit(a1);
    bus_stop();
    tests_run++;
    if (rx0_q.size() - rx_base != 1 || rx0_q[rx0_q.size() - 1] !== 8'hC3) begin
      tests_failed++; $display("FAIL abort_next_byte: got n=%0d last=%h want 1/c3",
                               rx0_q.size() - rx_base, rx0_q[rx0_q.size() - 1]);
    end
    $display("[TB] abort then c3 done");
  endtask

  task automatic test_reset_ack;
    logic a0, a1;
    int rx_base;
    bus_start();
    send_byte(8'h3C, 1'b1);
    sda_rel = 1'b1;
    wait_clk(Q);
    tests_run++;
    if (sda0 !== 1'b0) begin tests_failed++; $display("FAIL rstack_driving: got %b want 0", sda0); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (sda0 !== 1'b1) begin tests_failed++; $display("FAIL rstack_release: got %b want 1", sda0); end
    wait_clk(2);
    rst = 1'b0;
    scl_rel = 1'b1; wait_clk(2 * Q);
    scl_rel = 1'b0; wait_clk(Q);
    bus_stop();
    rx_base = rx0_q.size();
    bus_start();
    send_byte(8'h3C, 1'b1); recv_bit(a0);
    send_byte(8'h96, 1'b1); recv_bit(a1);
    bus_stop();
    tests_run++;
    if ({a0, a1} !== 2'b00 || rx0_q.size() - rx_base != 1 || rx0_q[rx0_q.size() - 1] !== 8'h96) begin
      tests_failed++; $display("FAIL rstack_next_write: got acks=%b n=%0d last=%h want 00/1/96",
                               {a0, a1}, rx0_q.size() - rx_base, rx0_q[rx0_q.size() - 1]);
    end
    $display("[TB] reset during ack then 96 done");
  endtask

  task automatic test_msb_first;
    logic a0, a1, a2;
    int base = rx1_q.size();
    int busy1_base = busy1_cnt;
    bus_sel = 1'b1;
    wait_clk(Q);
    bus_start();
    send_byte(8'h78, 1'b0); recv_bit(a0);
    send_byte(8'hA5, 1'b0); recv_bit(a1);
    send_byte(8'h5A, 1'b0); recv_bit(a2);
    bus_stop();
    wait_clk(Q);
    tests_run++;
    if ({a0, a1, a2} !== 3'b000) begin tests_failed++; $display("FAIL msb_acks: got %b want 000", {a0, a1, a2}); end
    tests_run++;
    if (rx1_q.size() - base != 2 || rx1_q[base] !== 8'hA5 || rx1_q[base + 1] !== 8'h5A) begin
      tests_failed++; $display("FAIL msb_bytes: got n=%0d first=%h want 2 bytes a5 5a",
                               rx1_q.size() - base, rx1_q[base]);
    end
    tests_run++;
    if (busy1_cnt == busy1_base || busy1 !== 1'b0 || treq1_cnt + nack1_cnt != 0) begin
      tests_failed++; $display("FAIL msb_busy: got cycles=%0d busy=%b req+nack=%0d want >0/0/0",
                               busy1_cnt - busy1_base, busy1, treq1_cnt + nack1_cnt);
    end
    bus_sel = 1'b0;
    $display("[TB] msb-first write a5 5a done");
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    scl_rel = 1'b1;
    sda_rel = 1'b1;
    bus_sel = 1'b0;
    t_byte  = 8'h00;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rep_start();
    test_abort();
    test_reset_ack();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
